// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key debounce front end.
// Holds the debounce FSM state encoding and the ms-to-cycles / counter
// width helpers used to size timers from millisecond parameters.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_e;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return clk_freq / 1000 * ms;
    endfunction

    // Width of a counter that runs 0..max_cnt-1; never narrower than 1 bit.
    function automatic int cnt_width(input int max_cnt);
        return (max_cnt > 1) ? $clog2(max_cnt) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous pin.
// RST_VAL sets the level both flops take during reset so that a pin's
// idle level does not look like an edge when reset is released.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_event.sv
// key_debounce_event: synchronises and debounces a raw key pin and emits
// single-cycle press / release / long-press pulses plus a debounced level.
// Optional auto-repeat pulses after a long press: define KEY_AUTO_REPEAT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | key released and stable
// PRESS_DB | pressed seen, waiting DB_CNT stable cycles before accepting
// HELD     | press accepted; hold_cnt times toward long press
// REL_DB   | release seen, waiting DB_CNT stable cycles; hold_cnt frozen
module key_debounce_event
    import key_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat
);

    localparam int DB_CNT   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int LONG_CNT = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int REP_CNT  = ms_to_cycles(CLK_FREQ, REPEAT_MS);

    localparam int DB_W   = cnt_width(DB_CNT);
    localparam int HOLD_W = cnt_width(LONG_CNT);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
    // One step before saturation: the increment out of this value fires long_press.
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CNT - 2);

    // Pin level when the key is not pressed.
    localparam logic PIN_IDLE = ACTIVE_LOW;

    logic key_sync;
    logic pressed_s;

    key_state_e        state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              level_nxt, press_nxt, rel_nxt, long_nxt;

    sync_2ff #(
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (key_sync)
    );

    assign pressed_s = key_sync ^ ACTIVE_LOW;

    // State, timers and registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_nxt;
            db_cnt      <= db_nxt;
            hold_cnt    <= hold_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= rel_nxt;
            long_press  <= long_nxt;
        end
    end

    // Next-state, timer updates and event pulse decode.
    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        hold_nxt  = hold_cnt;
        level_nxt = key_level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pressed_s) begin
                    state_nxt = PRESS_DB;
                    db_nxt    = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed_s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                // Saturating hold timer keeps long_press to a single pulse.
                if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                    long_nxt = (hold_cnt == HOLD_PRE);
                end
                if (!pressed_s) begin
                    state_nxt = REL_DB;
                    db_nxt    = '0;
                end
            end
            REL_DB: begin
                if (pressed_s) begin
                    state_nxt = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int REP_W = cnt_width(REP_CNT);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CNT - 1);

    logic [REP_W-1:0] rep_cnt, rep_nxt;
    logic             repeat_nxt;

    // Repeat timer runs only once the hold timer has saturated; clears on release.
    always_comb begin
        rep_nxt    = rep_cnt;
        repeat_nxt = 1'b0;
        if ((state == HELD) && (hold_cnt == HOLD_LAST)) begin
            if (rep_cnt == REP_LAST) begin
                rep_nxt    = '0;
                repeat_nxt = 1'b1;
            end else begin
                rep_nxt = rep_cnt + 1'b1;
            end
        end else if (rel_nxt) begin
            rep_nxt = '0;
        end
    end

    // Repeat timer and pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt    <= '0;
            key_repeat <= 1'b0;
        end else begin
            rep_cnt    <= rep_nxt;
            key_repeat <= repeat_nxt;
        end
    end
`else
    // Repeat period is kept as a parameter so builds share one interface.
    logic [31:0] unused_rep_cfg;
    assign unused_rep_cfg = REP_CNT;
    assign key_repeat     = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_event.sv
// tb_key_debounce_event: randomized and directed stimulus for
// key_debounce_event, checked every cycle against a run-length model of
// the debounce rules, plus literal timing expectations for key scenarios.
module tb_key_debounce_event;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic key_in;
    logic key_level, key_press, key_release, long_press, key_repeat;

    key_debounce_event #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .long_press  (long_press),
        .key_repeat  (key_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Observed DUT events
    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
    int press_at = -1, rel_at = -1, long_at = -1, rep_at = -1;

    // Model state: pin pipeline, debounced level, length of the current
    // run of cycles disagreeing with the level, held-cycle count, repeat count
    int m_s1, m_s2, m_level, m_run, m_held, m_repc;
    int e_level, e_press, e_rel, e_long, e_rep;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1;
        m_level = 0; m_run = 0; m_held = 0; m_repc = 0;
        e_level = 0; e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    endtask

    // Model step at a rising edge; pressed is taken from the pin two edges back.
    task automatic model_edge(input int pin);
        int p;
        p = (m_s2 == 0) ? 1 : 0;
        m_s2 = m_s1;
        m_s1 = pin;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        // Accepted press with no pending release debounce: counting held time
        if (m_level == 1 && m_run == 0) begin
            if (m_held == LONG - 1) begin
                m_repc++;
                if (m_repc == REP) begin
                    m_repc = 0;
                    e_rep  = REP_EN ? 1 : 0;
                end
            end else begin
                m_held++;
                if (m_held == LONG - 1) e_long = 1;
            end
        end
        // A change is accepted after DB+1 consecutive disagreeing cycles
        if (p != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_run   = 0;
                m_level = 1 - m_level;
                if (m_level == 1) begin
                    e_press = 1;
                    m_held  = 0;
                end else begin
                    e_rel  = 1;
                    m_repc = 0;
                end
            end
        end else begin
            m_run = 0;
        end
        e_level = m_level;
    endtask

    // Per-cycle compare against the model
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) model_reset();
            else     model_edge(int'(key_in));
            #1;
            chk("level",   int'(key_level),   e_level);
            chk("press",   int'(key_press),   e_press);
            chk("release", int'(key_release), e_rel);
            chk("long",    int'(long_press),  e_long);
            chk("repeat",  int'(key_repeat),  e_rep);
            if (key_press)   begin n_press++; press_at = cyc; end
            if (key_release) begin n_rel++;   rel_at   = cyc; end
            if (long_press)  begin n_long++;  long_at  = cyc; end
            if (key_repeat)  begin
                if (rep_at < long_at) rep_at = cyc;
                n_rep++;
            end
        end
    end

    task automatic hold_key(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, tr, p0, r0, l0, q0;
        rst    = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_level", int'(key_level), 0);
        chk("reset_pulses", int'({key_press, key_release, long_press, key_repeat}), 0);
        rst = 1'b0;
        hold_key(1'b1, 5);

        // Clean press: pulse after edge DB+3
        p0 = n_press; t0 = cyc;
        hold_key(1'b0, 10);
        chk("clean_press_count", n_press - p0, 1);
        chk("clean_press_latency", press_at - t0, 7);
        chk("clean_press_level", int'(key_level), 1);

        // Release with a one-cycle bounce
        p0 = n_press; r0 = n_rel;
        hold_key(1'b1, 2);
        hold_key(1'b0, 1);
        tr = cyc;
        hold_key(1'b1, 12);
        chk("rel_count", n_rel - r0, 1);
        chk("rel_latency", rel_at - tr, 7);
        chk("rel_no_press", n_press - p0, 0);
        chk("rel_level", int'(key_level), 0);

        // Short bounces are rejected
        p0 = n_press;
        repeat (5) begin
            hold_key(1'b0, 3);
            hold_key(1'b1, 3);
        end
        hold_key(1'b1, 6);
        chk("bounce_no_press", n_press - p0, 0);
        chk("bounce_level", int'(key_level), 0);

        // Long press, with auto-repeat when built in
        p0 = n_press; l0 = n_long; q0 = n_rep; r0 = n_rel;
        hold_key(1'b0, 40);
        hold_key(1'b1, 15);
        chk("long_press_count", n_press - p0, 1);
        chk("long_count", n_long - l0, 1);
        chk("long_delay", long_at - press_at, LONG - 1);
        chk("long_rep_count", n_rep - q0, REP_EN ? 3 : 0);
        chk("long_rel_count", n_rel - r0, 1);
`ifdef KEY_AUTO_REPEAT_EN
        chk("first_repeat_delay", rep_at - long_at, REP);
`endif

        // Asynchronous reset while held, then re-press from reset
        hold_key(1'b0, 15);
        chk("pre_reset_level", int'(key_level), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_level", int'(key_level), 0);
        chk("async_reset_pulses", int'({key_press, key_release, long_press, key_repeat}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        p0 = n_press; t0 = cyc;
        hold_key(1'b0, 10);
        chk("post_reset_press_count", n_press - p0, 1);
        chk("post_reset_latency", press_at - t0, 7);
        hold_key(1'b1, 12);

        // Randomized pin activity with occasional reset pulses
        for (int i = 0; i < 220; i++) begin
            int len;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 45) : $urandom_range(1, 8);
            hold_key(1'(($urandom_range(0, 1))), len);
        end
        hold_key(1'b1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
